npu_cube_csa_acc: RTL and testbench



---
 rtl/npu_cube_pkg.sv | 31 +++
 rtl/npu_cube_csa_row.sv | 15 +
 rtl/npu_cube_csa_acc.sv | 134 +++++++++++++
 tb/tb_npu_cube_csa_acc.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_cube_pkg.sv
// Shared types, default widths and operand slicing for the NPU cube CSA accumulator.
package npu_cube_pkg;

    typedef enum logic [1:0] {
        ACC,
        RESOLVE,
        HOLD
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NUM_IN = 4;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_CNT_W  = 8;

    localparam int BUS_MAX = 1024;
    localparam int OP_MAX  = 64;

    // Operand k of a packed bus, zero-extended to OP_MAX bits.
    function automatic logic [OP_MAX-1:0] op_slice(
        input logic [BUS_MAX-1:0] bus,
        input int                 k,
        input int                 w
    );
        logic [BUS_MAX-1:0] sh;
        logic [OP_MAX-1:0]  mask;
        sh   = bus >> (k * w);
        mask = (OP_MAX'(1) << w) - OP_MAX'(1);
        return OP_MAX'(sh) & mask;
    endfunction

endpackage

// File: rtl/npu_cube_csa_row.sv
// One row of per-bit 3:2 full adders; carry is returned unshifted.
module npu_cube_csa_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] cin,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/npu_cube_csa_acc.sv
// Carry-save accumulator: NUM_IN operands per beat, resolved by one CPA per group.
// Optional beat counter and out_cnt port enabled by NPU_CUBE_CSA_ACC_CNT_EN.
module npu_cube_csa_acc
    import npu_cube_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_sum
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
    ,
    output logic [CNT_W-1:0]        out_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;
    logic [ACC_W-1:0] tree_s;
    logic [ACC_W-1:0] tree_c;
    logic             accept;

    // Row k folds operand k into the running (sum, carry) pair.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_row
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] b;
        logic [ACC_W-1:0] op;
        logic [ACC_W-1:0] s;
        logic [ACC_W-1:0] cy;
        logic [ACC_W-1:0] c;

        if (k == 0) begin : g_first
            assign a = acc_s;
            assign b = acc_c;
        end else begin : g_next
            assign a = g_row[k-1].s;
            assign b = g_row[k-1].c;
        end

        assign op = ACC_W'(op_slice(BUS_MAX'(in_data), k, WIDTH));

        npu_cube_csa_row #(
            .WIDTH (ACC_W)
        ) u_row (
            .a     (a),
            .b     (b),
            .cin   (op),
            .sum   (s),
            .carry (cy)
        );

        assign c = cy << 1;
    end

    assign tree_s = g_row[NUM_IN-1].s;
    assign tree_c = g_row[NUM_IN-1].c;
    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = RESOLVE;
                end
            end
            RESOLVE: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc_s     <= '0;
            acc_c     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                acc_s <= tree_s;
                acc_c <= tree_c;
            end
            if (state == RESOLVE) begin
                out_sum   <= acc_s + acc_c;
                acc_s     <= '0;
                acc_c     <= '0;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NPU_CUBE_CSA_ACC_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            out_cnt <= '0;
        end else if (state == RESOLVE) begin
            out_cnt <= cnt;
            cnt     <= '0;
        end else if (accept && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_cnt_w;
    assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_npu_cube_csa_acc.sv
// Scoreboard bench for npu_cube_csa_acc (ACC_W=24 and a wrapping ACC_W=10 copy).
module tb_npu_cube_csa_acc;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
        int          exp_sum;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        int sum;
        int cnt;
    } exp_t;

    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_sum;
    logic        in_ready_w;
    logic        out_valid_w;
    logic [9:0]  out_sum_w;
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
    logic [7:0]  out_cnt;
    logic [7:0]  out_cnt_w;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];
    vec_t tbl[NV];

    always #5 clk = ~clk;

    npu_cube_csa_acc #(
        .WIDTH (8), .NUM_IN (4), .ACC_W (24), .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
        ,
        .out_cnt   (out_cnt)
`endif
    );

    npu_cube_csa_acc #(
        .WIDTH (8), .NUM_IN (4), .ACC_W (10), .CNT_W (8)
    ) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .out_sum   (out_sum_w)
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
        ,
        .out_cnt   (out_cnt_w)
`endif
    );

    task automatic check(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Scoreboard: compare every result at the cycle its handshake completes.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sum24", out_sum, e.sum % (1 << 24));
                check("sum10_wrap", out_sum_w, e.sum % 1024);
                check("valid_w", out_valid_w, 1);
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
                check("cnt", out_cnt, e.cnt);
                check("cnt_w", out_cnt_w, e.cnt);
`endif
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l,
                        input int es, input int ec);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        if (l) sbq.push_back('{es, ec});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(nm, out_valid, 1);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(nm, sbq.size(), 0);
    endtask

    initial begin
        tbl[0] = '{32'h04030201, 1'b1, 0, 10, 1};
        tbl[1] = '{32'hFFFFFFFF, 1'b0, 0, 0, 0};
        tbl[2] = '{32'hFFFFFFFF, 1'b0, 0, 0, 0};
        tbl[3] = '{32'hFFFFFFFF, 1'b1, 0, 3060, 3};
        tbl[4] = '{32'h10204080, 1'b1, 3, 240, 1};
        tbl[5] = '{32'h01010101, 1'b0, 0, 0, 0};
        tbl[6] = '{32'h02020202, 1'b1, 4, 12, 2};
        tbl[7] = '{32'h00000000, 1'b1, 0, 0, 1};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_sum_w", out_sum_w, 0);
`ifdef NPU_CUBE_CSA_ACC_CNT_EN
        check("rst_out_cnt", out_cnt, 0);
`endif

        for (int i = 0; i < NV; i++) begin
            repeat (tbl[i].gap) @(posedge clk);
            send(tbl[i].data, tbl[i].last, tbl[i].exp_sum, tbl[i].exp_cnt);
        end
        drain("table_drain");

        // Latency: accept at edge t, out_valid seen after edge t+1.
        send(32'h04030201, 1'b1, 10, 1);
        @(negedge clk);
        check("lat_resolve_valid", out_valid, 0);
        check("lat_resolve_ready", in_ready, 0);
        @(negedge clk);
        check("lat_hold_valid", out_valid, 1);
        drain("lat_drain");

        // Counter saturation over a long group.
        for (int i = 0; i < 260; i++) begin
            send(32'h01010101, 1'(i == 259), 1040, 255);
        end
        drain("sat_drain");

        // Back-pressure with garbage offered while busy.
        out_ready = 1'b0;
        send(32'h05050505, 1'b1, 20, 1);
        wait_valid("bp_valid");
        in_valid = 1'b1;
        in_data  = 32'hFFFFFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_stable", out_valid, 1);
            check("bp_sum_stable", out_sum, 20);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        drain("bp_drain");

        // Reset during HOLD drops the pending result.
        out_ready = 1'b0;
        send(32'h01010101, 1'b1, 4, 1);
        wait_valid("hold_valid");
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        void'(sbq.pop_back());
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", out_valid, 0);
        check("hold_rst_ready", in_ready, 1);
        check("hold_rst_sum", out_sum, 0);

        // Reset mid-group discards the partial sum.
        send(32'h0A0A0A0A, 1'b0, 0, 0);
        send(32'h0A0A0A0A, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h05000000, 1'b1, 5, 1);
        drain("midrst_drain");

        repeat (3) @(negedge clk);
        check("final_queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
